rs232_to_axis: RTL and testbench
================================

// Module: rs232_to_axis
// PURPOSE
//  RS232 serial receiver with hardware flow control; companion of the
//  AXI-stream-to-RS232 transmitter. Samples rxd_pin (8N1, LSB first) at
//  mid-bit, buffers received bytes in a small FIFO and presents them as an
//  AXI byte stream. Drives rtsn_pin high (stop) before the FIFO overflows.
//  Connect rxd_pin to the remote TXD; connect rtsn_pin to the remote CTSn.
// PARAMETERS
//  CLOCK_FREQ  133000000  clock frequency in Hz (real)
//  BAUD_RATE   115200     serial bit rate (real); BAUD_COUNT = CLOCK_FREQ/BAUD_RATE, >= 4
//  FIFO_DEPTH  4          receive FIFO entries, power of two, >= 4
//  RTS_MARGIN  2          free entries below which rtsn_pin is raised, 1..FIFO_DEPTH-1
// PORTS
//  clock        in   1  system clock, all logic on rising edge
//  resetn       in   1  asynchronous, active-low reset
//  rxd_pin      in   1  serial input, idle high, asynchronous to clock
//  rtsn_pin     out  1  0 = remote may send, 1 = remote must stop
//  odata        out  8  received byte at FIFO head
//  ovalid       out  1  odata valid (FIFO not empty)
//  oready       in   1  consumer accepts odata when ovalid && oready
//  frame_error  out  1  one-cycle pulse: stop bit sampled as 0, byte dropped
//  overrun      out  1  one-cycle pulse: good byte arrived with FIFO full, byte dropped
// BEHAVIOUR
//  Reset: rtsn_pin=1, ovalid=0, odata=0, frame_error=0, overrun=0, FIFO empty,
//   FSM=IDLE, rxd synchroniser=2'b11. Reset mid-frame aborts the frame silently.
//  Synchroniser: two flops on rxd_pin; "rxd" below is the second flop output.
//  Baud counter: counts down; loaded with BAUD_COUNT/2-1 on start edge, with
//   BAUD_COUNT-1 on each sample tick; sample tick when it reaches 0.
//  FSM:
//   IDLE  : rxd==0 -> START (load half-bit count). Otherwise stay.
//   START : at tick, rxd==1 -> IDLE (glitch, no outputs); rxd==0 -> DATA, bit=0.
//   DATA  : at each tick shift rxd into shift[7] (right shift, LSB first);
//           after 8th sample -> STOP.
//   STOP  : at tick: rxd==1 and FIFO not full (or popping same cycle) -> push
//           shift; rxd==1 and FIFO full -> overrun=1 for 1 cycle; go IDLE.
//           rxd==0 -> frame_error=1 for 1 cycle, go BREAK.
//   BREAK : wait until rxd==1, then IDLE (a held-low line yields one error only).
//  Returning to IDLE at mid-stop-bit lets back-to-back frames resynchronise.
//  FIFO: circular, write/read pointers log2(FIFO_DEPTH)+1 bits (wrap bit for
//   full/empty). odata/ovalid driven from head; pop on ovalid && oready.
//   Simultaneous push and pop allowed in any state incl. full; count unchanged.
//   odata holds its value while ovalid && !oready. Byte visible on ovalid the
//   cycle after the stop-bit push.
//  Flow control: rtsn_pin registered; 1 when free entries (after this cycle's
//   push/pop) < RTS_MARGIN, else 0. First 0 one cycle after reset release.
//  Latency: start edge on pin to ovalid ~ 2 + 9.5*BAUD_COUNT + 1 cycles.
//  Bit-time rounding: BAUD_COUNT truncated to integer; mid-bit sampling must
//   tolerate +/-3% rate mismatch.
// TESTING
//  (CLOCK_FREQ=1600000, BAUD_RATE=100000 -> BAUD_COUNT=16, FIFO_DEPTH=4, RTS_MARGIN=2)
//  1 Send 0xA5 8N1, oready=1 -> single ovalid beat with odata=0xA5, no error pulses.
//  2 Send 0x00,0xFF,0x55,0x3C back-to-back (no idle), oready=0 -> FIFO fills,
//    rtsn_pin rises after 3rd byte push, then drain yields 00,FF,55,3C in order.
//  3 With FIFO full, send 0x77 -> overrun pulses once, FIFO contents unchanged.
//  4 Send 0x81 with stop bit 0, line high after -> frame_error pulse, no push;
//    hold rxd low 40 bit times -> exactly one frame_error.
//  5 4-cycle low glitch on idle rxd -> returns to IDLE, no output, no error.
//  6 Assert resetn=0 mid-byte (after bit 3) -> all outputs at reset values;
//    next full frame 0x5A received correctly. Repeat tests 1-2 with baud
//    rate +3% and -3% -> identical results.

Source files
------------

// File: rtl/rs232_to_axis.sv
// RS232 8N1 receiver with mid-bit sampling, receive FIFO, AXI byte-stream output
// and RTS flow control that stops the remote before the FIFO can overflow.
module rs232_to_axis #(
  parameter real         CLOCK_FREQ = 133000000.0,
  parameter real         BAUD_RATE  = 115200.0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RTS_MARGIN = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       rxd_pin,
  output logic       rtsn_pin,
  output logic [7:0] odata,
  output logic       ovalid,
  input  logic       oready,
  output logic       frame_error,
  output logic       overrun
);

  localparam int unsigned BAUD_COUNT = $rtoi(CLOCK_FREQ / BAUD_RATE);
  localparam int unsigned CW         = $clog2(BAUD_COUNT);
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_COUNT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_COUNT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   RTS_LEVEL = (AW + 1)'(FIFO_DEPTH - RTS_MARGIN);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state, state_nx;
  logic [1:0]    rxd_sync;
  logic          rxd;
  logic [CW-1:0] baud_cnt;
  logic          tick;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, count, count_nx;
  logic          full, push, pop, frame_err_nx, overrun_nx;

  assign rxd      = rxd_sync[1];
  assign tick     = (baud_cnt == '0);
  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == DEPTH_C);
  assign ovalid   = (wr_ptr != rd_ptr);
  assign pop      = ovalid && oready;
  assign odata    = mem[rd_ptr[AW-1:0]];
  assign count_nx = count + (AW + 1)'(push) - (AW + 1)'(pop);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rxd_sync <= 2'b11;
      state    <= IDLE;
    end else begin
      rxd_sync <= {rxd_sync[0], rxd_pin};
      state    <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    push         = 1'b0;
    frame_err_nx = 1'b0;
    overrun_nx   = 1'b0;
    unique case (state)
      IDLE:  if (!rxd) state_nx = START;
      START: if (tick) state_nx = rxd ? IDLE : DATA;
      DATA:  if (tick && bit_idx == 3'd7) state_nx = STOP;
      STOP: begin
        if (tick) begin
          if (rxd) begin
            // leaving at mid-stop-bit lets a back-to-back start edge resync us
            state_nx = IDLE;
            if (!full || pop) push = 1'b1;
            else              overrun_nx = 1'b1;
          end else begin
            state_nx     = BRK;
            frame_err_nx = 1'b1;
          end
        end
      end
      BRK:     if (rxd) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      if (state == IDLE) begin
        if (!rxd) baud_cnt <= HALF_LOAD;
      end else if (state != BRK) begin
        baud_cnt <= tick ? FULL_LOAD : baud_cnt - CNT_ONE;
      end
      if (state == START) bit_idx <= '0;
      if (state == DATA && tick) begin
        shift   <= {rxd, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rtsn_pin    <= 1'b1;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= shift;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      // raise stop when free entries after this cycle fall below the margin
      rtsn_pin    <= (count_nx > RTS_LEVEL);
      frame_error <= frame_err_nx;
      overrun     <= overrun_nx;
    end
  end

endmodule

// File: tb/tb_rs232_to_axis.sv
// Self-checking bench for rs232_to_axis: frame-level reference model of the
// FIFO contents, error pulses and flow control, checked on every cycle.
`timescale 1ns/1ps
module tb_rs232_to_axis;

  localparam int DEPTH  = 4;
  localparam int MARGIN = 2;

  logic       clock = 1'b0;
  logic       resetn;
  logic       rxd_pin;
  logic       rtsn_pin;
  logic [7:0] odata;
  logic       ovalid;
  logic       oready;
  logic       frame_error;
  logic       overrun;

  logic oready_main = 1'b0;
  logic oready_rand = 1'b0;
  logic rand_mode   = 1'b0;
  assign oready = rand_mode ? oready_rand : oready_main;

  rs232_to_axis #(
    .CLOCK_FREQ(1600000.0),
    .BAUD_RATE (100000.0),
    .FIFO_DEPTH(DEPTH),
    .RTS_MARGIN(MARGIN)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .rxd_pin    (rxd_pin),
    .rtsn_pin   (rtsn_pin),
    .odata      (odata),
    .ovalid     (ovalid),
    .oready     (oready),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] model_q[$];
  logic [7:0] got[$];
  int exp_fe = 0, exp_ov = 0, fe_cnt = 0, ov_cnt = 0;
  int rts_rise_size = -1;
  logic prev_rts = 1'b1;
  logic settled = 1'b0;
  real bit_ns = 160.0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // compare process: checks DUT against the model on every falling edge
  initial begin
    forever begin
      @(negedge clock);
      if (resetn) begin
        fe_cnt += int'(frame_error);
        ov_cnt += int'(overrun);
        if (!prev_rts && rtsn_pin && rts_rise_size < 0) rts_rise_size = model_q.size();
        prev_rts = rtsn_pin;
        if (settled) begin
          chk("ovalid_model", ovalid, model_q.size() > 0);
          chk("rtsn_model", rtsn_pin, (DEPTH - int'(model_q.size())) < MARGIN);
          if (ovalid && model_q.size() > 0) chk("odata_head", odata, model_q[0]);
        end
        if (ovalid && oready) begin
          if (model_q.size() == 0) chk("unexpected_beat", ovalid, 1'b0);
          else chk("beat_data", odata, model_q.pop_front());
          got.push_back(odata);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clock);
      #2 oready_rand = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

  // Sends one 8N1 frame; the model takes the byte when the stop bit starts.
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic settle);
    settled = 1'b0;
    rxd_pin = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rxd_pin = b[i];
      #(bit_ns);
    end
    if (stop_ok) begin
      if (model_q.size() < DEPTH) model_q.push_back(b);
      else exp_ov++;
    end else begin
      exp_fe++;
    end
    rxd_pin = stop_ok;
    #(bit_ns);
    rxd_pin = 1'b1;
    if (settle) begin
      repeat (3) @(posedge clock);
      settled = 1'b1;
    end
  endtask

  task automatic wait_drain(input string name);
    int w = 0;
    while (model_q.size() != 0 && w < 1000) begin
      @(posedge clock);
      w++;
    end
    chk(name, model_q.size(), 0);
    repeat (3) @(posedge clock);
  endtask

  task automatic check_reset_vals(input string name);
    chk(name, {rtsn_pin, ovalid, odata, frame_error, overrun}, {1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
  endtask

  task automatic run_basic(input string tag);
    int base;
    // single frame, consumer always ready
    oready_main = 1'b1;
    base = got.size();
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (4) @(posedge clock);
    chk({tag, "_a5_beats"}, got.size() - base, 1);
    if (got.size() > base) chk({tag, "_a5_data"}, got[base], 8'hA5);
    chk({tag, "_a5_fe"}, fe_cnt, exp_fe);
    chk({tag, "_a5_ov"}, ov_cnt, exp_ov);
    // back-to-back burst into a stalled consumer
    oready_main = 1'b0;
    rts_rise_size = -1;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b1);
    chk({tag, "_rts_rise_after"}, rts_rise_size, 3);
    chk({tag, "_full_rtsn"}, rtsn_pin, 1'b1);
    // extra byte while full
    send_frame(8'h77, 1'b1, 1'b1);
    repeat (4) @(posedge clock);
    chk({tag, "_overrun_cnt"}, ov_cnt, exp_ov);
    chk({tag, "_still_full"}, model_q.size(), DEPTH);
    base = got.size();
    oready_main = 1'b1;
    wait_drain({tag, "_drain"});
    chk({tag, "_drain_n"}, got.size() - base, 4);
    if (got.size() >= base + 4)
      chk({tag, "_drain_order"}, {got[base], got[base+1], got[base+2], got[base+3]}, 32'h00FF553C);
    chk({tag, "_drained_rtsn"}, rtsn_pin, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    logic       ok;
    int         w;
    rxd_pin = 1'b1;
    resetn  = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_vals("reset_vals");
    resetn = 1'b1;
    @(negedge clock);
    chk("rtsn_after_release", rtsn_pin, 1'b0);
    settled = 1'b1;

    bit_ns = 160.0;
    run_basic("nom");

    // bad stop bit, then a line held low for 40 bit times
    send_frame(8'h81, 1'b0, 1'b1);
    repeat (4) @(posedge clock);
    chk("frame_err_once", fe_cnt, exp_fe);
    settled = 1'b0;
    rxd_pin = 1'b0;
    #(40 * bit_ns);
    rxd_pin = 1'b1;
    exp_fe++;
    #(3 * bit_ns);
    settled = 1'b1;
    chk("held_low_one_err", fe_cnt, exp_fe);
    chk("held_low_no_push", got.size() + model_q.size(), got.size());

    // short glitch on the idle line
    w = got.size();
    @(posedge clock);
    #1 rxd_pin = 1'b0;
    repeat (4) @(posedge clock);
    #1 rxd_pin = 1'b1;
    #(2 * bit_ns);
    chk("glitch_no_beat", got.size() - w, 0);
    chk("glitch_no_fe", fe_cnt, exp_fe);
    chk("glitch_no_ov", ov_cnt, exp_ov);

    // reset in the middle of a frame
    settled = 1'b0;
    b = 8'hC3;
    rxd_pin = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 4; i++) begin
      rxd_pin = b[i];
      #(bit_ns);
    end
    resetn = 1'b0;
    #1;
    @(negedge clock);
    check_reset_vals("midframe_reset_vals");
    model_q.delete();
    rxd_pin = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    prev_rts = 1'b1;
    @(negedge clock);
    chk("rtsn_after_rerelease", rtsn_pin, 1'b0);
    settled = 1'b1;
    w = got.size();
    oready_main = 1'b1;
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (4) @(posedge clock);
    chk("after_reset_beats", got.size() - w, 1);
    if (got.size() > w) chk("after_reset_data", got[w], 8'h5A);

    // remote clock 3% fast, then 3% slow
    bit_ns = 160.0 / 1.03;
    run_basic("fast");
    bit_ns = 160.0 / 0.97;
    run_basic("slow");

    // randomized traffic with a randomly stalling consumer
    bit_ns = 160.0;
    settled = 1'b0;
    rand_mode = 1'b1;
    for (int n = 0; n < 24; n++) begin
      w = 0;
      while (model_q.size() >= DEPTH && w < 2000) begin
        @(posedge clock);
        w++;
      end
      chk("rand_space", model_q.size() < DEPTH, 1'b1);
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      send_frame(b, ok, 1'b0);
      if (!ok || $urandom_range(0, 1) == 1) #(bit_ns * $urandom_range(1, 3));
    end
    @(posedge clock);
    #2;
    rand_mode   = 1'b0;
    oready_main = 1'b1;
    wait_drain("rand_drain");
    settled = 1'b1;
    repeat (4) @(posedge clock);
    chk("rand_fe_total", fe_cnt, exp_fe);
    chk("rand_ov_total", ov_cnt, exp_ov);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
